// File: rtl/fft_pkg.sv
// Shared constants, bin type and frame FSM state encoding for the power path.
package fft_pkg;

    localparam int POWER_W = 53;
    localparam int IDX_W   = 11;

    // Peak location: {column, column index, lane}
    typedef logic [13:0] bin_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_t;

endpackage

// File: rtl/power_beat_reduce.sv
// Registered 8-to-1 reduction of one power beat: sample sum, maximum and
// the bin of that maximum. Ties go to the lowest bin (col1 lanes 0..3, then
// col2 lanes 0..3). Max/bin logic exists only with POWER_PEAK_DETECT_EN.
module power_beat_reduce
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = POWER_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [3:0][DATA_WIDTH-1:0] in_col1,
    input  logic [3:0][DATA_WIDTH-1:0] in_col2,
    input  logic [IDX_W-1:0]           in_idx_col1,
    input  logic [IDX_W-1:0]           in_idx_col2,
    output logic                       red_valid,
    output logic [DATA_WIDTH+2:0]      red_sum,
    output logic                       red_sync
`ifdef POWER_PEAK_DETECT_EN
    ,
    output logic [DATA_WIDTH-1:0]      red_max,
    output bin_t                       red_bin
`endif
);

    localparam int SUM_W = DATA_WIDTH + 3;

    logic [SUM_W-1:0] sum_c;

    // Eight-sample sum, widened so it can never overflow
    always_comb begin
        sum_c = '0;
        for (int l = 0; l < 4; l++) begin
            sum_c = sum_c + SUM_W'(in_col1[l]) + SUM_W'(in_col2[l]);
        end
    end

`ifdef POWER_PEAK_DETECT_EN
    logic [DATA_WIDTH-1:0] max_c;
    bin_t                  bin_c;

    // Scan in bin order, replacing only on strictly greater so ties keep the lowest bin
    always_comb begin
        max_c = in_col1[0];
        bin_c = {1'b0, in_idx_col1, 2'd0};
        for (int l = 1; l < 4; l++) begin
            if (in_col1[l] > max_c) begin
                max_c = in_col1[l];
                bin_c = {1'b0, in_idx_col1, 2'(l)};
            end
        end
        for (int l = 0; l < 4; l++) begin
            if (in_col2[l] > max_c) begin
                max_c = in_col2[l];
                bin_c = {1'b1, in_idx_col2, 2'(l)};
            end
        end
    end

    // Register the max/bin of each valid beat
    always_ff @(posedge clk) begin
        if (rst) begin
            red_max <= '0;
            red_bin <= '0;
        end else if (in_valid) begin
            red_max <= max_c;
            red_bin <= bin_c;
        end
    end
`else
    logic unused_idx_col2;
    assign unused_idx_col2 = ^in_idx_col2;
`endif

    // Register the sum, the frame-start marker and the beat valid
    always_ff @(posedge clk) begin
        if (rst) begin
            red_valid <= 1'b0;
            red_sum   <= '0;
            red_sync  <= 1'b0;
        end else begin
            red_valid <= in_valid;
            if (in_valid) begin
                red_sum  <= sum_c;
                red_sync <= (in_idx_col1 == '0);
            end
        end
    end

endmodule

// File: rtl/power_frame_reduce.sv
// Frame reduction of power beats: energy sum, peak value and peak bin over
// BEATS_PER_FRAME beats, with a held valid/ready result, sticky overrun and
// sticky resync flags. Peak tracking is built only when POWER_PEAK_DETECT_EN
// is defined; otherwise out_peak and out_peak_bin read 0.
module power_frame_reduce
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH      = POWER_W,
    parameter int BEATS_PER_FRAME = 512,
    parameter int ACC_WIDTH       = DATA_WIDTH + 3 + $clog2(BEATS_PER_FRAME)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [3:0][DATA_WIDTH-1:0] in_col1,
    input  logic [3:0][DATA_WIDTH-1:0] in_col2,
    input  logic [IDX_W-1:0]           in_idx_col1,
    input  logic [IDX_W-1:0]           in_idx_col2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_energy,
    output logic [DATA_WIDTH-1:0]      out_peak,
    output bin_t                       out_peak_bin,
    output logic                       overrun,
    output logic                       sync_err
);

    localparam int CNT_W = $clog2(BEATS_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

    logic                  red_valid;
    logic [DATA_WIDTH+2:0] red_sum;
    logic                  red_sync;

    frame_state_t          state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [ACC_WIDTH-1:0]  acc_energy;

    logic                  restart;
    logic                  first_beat;
    logic                  frame_done;
    logic [ACC_WIDTH-1:0]  next_energy;

`ifdef POWER_PEAK_DETECT_EN
    logic [DATA_WIDTH-1:0] red_max;
    bin_t                  red_bin;
    logic [DATA_WIDTH-1:0] acc_peak;
    bin_t                  acc_bin;
    logic [DATA_WIDTH-1:0] next_peak;
    bin_t                  next_bin;
`endif

    power_beat_reduce #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_reduce (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_col1     (in_col1),
        .in_col2     (in_col2),
        .in_idx_col1 (in_idx_col1),
        .in_idx_col2 (in_idx_col2),
        .red_valid   (red_valid),
        .red_sum     (red_sum),
        .red_sync    (red_sync)
`ifdef POWER_PEAK_DETECT_EN
        ,
        .red_max     (red_max),
        .red_bin     (red_bin)
`endif
    );

    // A frame-start beat arriving mid-frame restarts the frame from that beat
    always_comb begin
        restart     = red_valid && red_sync && (beat_cnt != '0);
        first_beat  = (state == ST_IDLE) || restart;
        frame_done  = red_valid && !restart && (state == ST_ACCUM) && (beat_cnt == LAST_BEAT);
        next_energy = first_beat ? ACC_WIDTH'(red_sum) : acc_energy + ACC_WIDTH'(red_sum);
    end

    // Frame FSM, energy accumulator and the held result with its handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            acc_energy <= '0;
            sync_err   <= 1'b0;
            out_valid  <= 1'b0;
            out_energy <= '0;
            overrun    <= 1'b0;
        end else begin
            if (red_valid) begin
                if (frame_done) begin
                    state      <= ST_IDLE;
                    beat_cnt   <= '0;
                    acc_energy <= '0;
                end else begin
                    state      <= ST_ACCUM;
                    beat_cnt   <= restart ? CNT_W'(1) : beat_cnt + CNT_W'(1);
                    acc_energy <= next_energy;
                end
                if (restart) begin
                    sync_err <= 1'b1;
                end
            end
            if (frame_done) begin
                out_valid  <= 1'b1;
                out_energy <= next_energy;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef POWER_PEAK_DETECT_EN
    // Strictly-greater update keeps the earliest beat on equal peaks
    always_comb begin
        if (first_beat || (red_max > acc_peak)) begin
            next_peak = red_max;
            next_bin  = red_bin;
        end else begin
            next_peak = acc_peak;
            next_bin  = acc_bin;
        end
    end

    // Peak tracker and its output registers, loaded alongside the energy
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_peak     <= '0;
            acc_bin      <= '0;
            out_peak     <= '0;
            out_peak_bin <= '0;
        end else if (red_valid) begin
            if (frame_done) begin
                acc_peak     <= '0;
                acc_bin      <= '0;
                out_peak     <= next_peak;
                out_peak_bin <= next_bin;
            end else begin
                acc_peak <= next_peak;
                acc_bin  <= next_bin;
            end
        end
    end
`else
    assign out_peak     = '0;
    assign out_peak_bin = '0;
`endif

endmodule

// File: doc/power_frame_reduce.md
POWER_FRAME_REDUCE -- requirements
Module: power_frame_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 53, meaning the width of each unsigned power sample.
REQ-002 SHALL have parameter BEATS_PER_FRAME, default 512, meaning the number of input beats per frame (power of 2, at least 2).
REQ-003 SHALL have parameter ACC_WIDTH, default DATA_WIDTH+3+$clog2(BEATS_PER_FRAME), meaning the width of the frame energy accumulator.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  beat valid, driven by the upstream power stage's ready output; no backpressure.
REQ-007 in_col1, in_col2  input  [3:0][DATA_WIDTH-1:0] each  four-lane unsigned power samples per column.
REQ-008 in_idx_col1, in_idx_col2  input  11 each  column indices aligned with the samples.
REQ-009 out_valid  output  1  frame result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_energy  output  ACC_WIDTH  sum of all 8*BEATS_PER_FRAME samples in the frame.
REQ-012 out_peak  output  DATA_WIDTH  maximum sample in the frame.
REQ-013 out_peak_bin  output  14  location of the peak: bit13 = column (0 = col1), bits12:2 = index, bits1:0 = lane.
REQ-014 overrun  output  1  sticky flag; a frame result was overwritten before it was accepted.
REQ-015 sync_err  output  1  sticky flag; the frame was resynchronised early.

Function
REQ-016 SHALL register one reduction stage per valid beat: the 8-sample sum, the 8-sample maximum, and its 14-bit bin; this stage has 1-cycle latency.
REQ-017 SHALL resolve maximum ties to the lowest bin, ordering col1 lanes 0..3 before col2 lanes 0..3.
REQ-018 SHALL accumulate the reduced sum into the energy register and update the peak only on a strictly greater value, so the earliest beat wins ties.
REQ-019 SHALL implement a two-state FSM: IDLE (beat count 0, accumulators cleared) and ACCUM; the first reduced valid beat moves IDLE to ACCUM.
REQ-020 SHALL count beats 0..BEATS_PER_FRAME-1; on the last beat, load the final values into the output registers, assert out_valid, and re-enter IDLE with the accumulators cleared.
REQ-021 SHALL assert out_valid exactly 2 cycles after the in_valid of the last beat of a frame, with no idle gap required between frames.
REQ-022 SHALL hold out_valid and all out_* values stable until the cycle where out_valid and out_ready are both high, then deassert out_valid on the next cycle unless a new result loads that same cycle.
REQ-023 On a new frame result while out_valid=1 and out_ready=0, SHALL overwrite the output registers, keep out_valid high and set overrun.
REQ-024 On a new frame result in the same cycle that the previous result is accepted, SHALL load the new result with no overrun.
REQ-025 On a reduced beat with in_idx_col1==0 while the beat count is nonzero, SHALL discard the partial frame, set sync_err, and restart counting with this beat as beat 0.
REQ-026 SHALL never wrap the accumulator; ACC_WIDTH covers the worst-case sum by construction.

Reset
REQ-027 Reset SHALL set: out_valid=0; out_energy, out_peak, out_peak_bin, overrun and sync_err all 0; FSM=IDLE; beat count and accumulators 0; reduction stage cleared.
REQ-028 Reset asserted mid-frame or mid-handshake SHALL abandon all state without emitting a result.
REQ-029 Reset SHALL be the only way to clear the sticky flags.

Configuration
REQ-030 Macro POWER_PEAK_DETECT_EN defined SHALL compile in the max/bin reduction and peak tracking.
REQ-031 Macro POWER_PEAK_DETECT_EN undefined SHALL remove that logic and tie out_peak and out_peak_bin to 0; energy behaviour and latency are unchanged.

Structure
REQ-032 The shared package fft_pkg SHALL hold: the POWER_W=53 constant, the IDX_W=11 constant, the bin_t 14-bit typedef, and the FSM state enum.
REQ-033 SHALL instantiate exactly one sub-module, power_beat_reduce, which is the registered 8-to-1 sum/max/bin stage.

Verification (BEATS_PER_FRAME=4)
REQ-034 4 beats, all samples 1, out_ready=1 -> out_energy=32, out_peak=1, out_peak_bin=0, out_valid high 2 cycles after the last beat.
REQ-035 Beat 2 (in_idx_col1=2) with col2 lane3=1000, all others 5 -> out_energy=1155, out_peak=1000, out_peak_bin=0x200B.
REQ-036 Two back-to-back frames with out_ready=0 -> overrun=1 and the outputs hold frame 2; then out_ready=1 -> one accept, after which out_valid=0.
REQ-037 Beats with in_idx_col1 = 0,1,0,1,2,3 -> sync_err=1 and exactly one result, covering the last 4 beats.
REQ-038 rst pulsed after beat 2 -> no out_valid; a fresh 4-beat frame then yields a correct result.
REQ-039 All samples at 2^53-1 for 4 beats -> out_energy=32*(2^53-1) with no wrap; with POWER_PEAK_DETECT_EN undefined, out_peak=0.
